// File: rtl/stonyman_pkg.sv
// Shared definitions for the Stonyman frame readout sequencer.
//   - state_t   : sequencer FSM states (exposed on the top-level debug port)
//   - ADC_*     : framing of the 12-bit serial ADC word (16 clocks, 4 leading zeros)
//   - COORD_W   : width of the row/column counters and pixel coordinates
package stonyman_pkg;

  localparam int ADC_FRAME_BITS = 16;
  localparam int ADC_LEAD_ZEROS = 4;
  localparam int ADC_BITS       = ADC_FRAME_BITS - ADC_LEAD_ZEROS;
  localparam int COORD_W        = 7;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_RST_V  = 4'd1,
    S_RST_P  = 4'd2,
    S_SETTLE = 4'd3,
    S_CONV   = 4'd4,
    S_EMIT   = 4'd5,
    S_INC_P  = 4'd6,
    S_INC_V  = 4'd7,
    S_DONE   = 4'd8
  } state_t;

endpackage

// File: rtl/stonyman_readout_adc_spi_rx.sv
// Serial ADC receiver: generates cs / SPI_CLK for one 16-clock conversion and
// shifts in miso. Handshake: a one-cycle i_conv_start while idle launches a
// conversion; a one-cycle o_conv_done marks o_data valid (held until the next
// conversion completes). i_abort drops cs/SPI_CLK to idle on the next cycle
// and suppresses o_conv_done.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_conv_start        one-cycle conversion request (ignored while active)
//   i_abort             synchronous cancel
//   i_miso              ADC serial data
//   o_cs                chip select, active low
//   o_sclk              serial clock, idles high
//   o_conv_done         one-cycle completion strobe
//   o_data[11:0]        last converted value
module adc_spi_rx
  import stonyman_pkg::*;
#(
  parameter int SCLK_DIV = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_conv_start,
  input  logic                i_abort,
  input  logic                i_miso,
  output logic                o_cs,
  output logic                o_sclk,
  output logic                o_conv_done,
  output logic [ADC_BITS-1:0] o_data
);

  localparam int DIV_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int HALF_W = $clog2(2 * ADC_FRAME_BITS);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCLK_DIV - 1);
  localparam logic [HALF_W-1:0] LAST_HALF = HALF_W'(2 * ADC_FRAME_BITS - 1);

  logic                r_active;
  logic                r_cs;
  logic                r_sclk;
  logic                r_done;
  logic [DIV_W-1:0]    r_div;
  logic [HALF_W-1:0]   r_half;
  logic [ADC_BITS-1:0] r_shift;
  logic [ADC_BITS-1:0] r_data;

  // cs and SPI_CLK fall together; even half-periods are low, odd are high,
  // so the 16th rising edge starts the last half and cs rises after it.
  // All 16 bits go through a 12-bit shifter: the 4 leading bits fall off the
  // top, leaving bits 5..16 MSB-first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_cs     <= 1'b1;
      r_sclk   <= 1'b1;
      r_done   <= 1'b0;
      r_div    <= '0;
      r_half   <= '0;
      r_shift  <= '0;
      r_data   <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_abort) begin
        r_active <= 1'b0;
        r_cs     <= 1'b1;
        r_sclk   <= 1'b1;
        r_div    <= '0;
        r_half   <= '0;
      end else if (!r_active) begin
        if (i_conv_start) begin
          r_active <= 1'b1;
          r_cs     <= 1'b0;
          r_sclk   <= 1'b0;
          r_div    <= '0;
          r_half   <= '0;
        end
      end else if (r_div != DIV_LAST) begin
        r_div <= r_div + DIV_W'(1);
      end else begin
        r_div <= '0;
        if (r_half == LAST_HALF) begin
          r_active <= 1'b0;
          r_cs     <= 1'b1;
          r_sclk   <= 1'b1;
          r_done   <= 1'b1;
          r_data   <= r_shift;
        end else begin
          r_half <= r_half + HALF_W'(1);
          r_sclk <= ~r_sclk;
          // sample on the cycle SPI_CLK goes low->high
          if (!r_sclk) r_shift <= {r_shift[ADC_BITS-2:0], i_miso};
        end
      end
    end
  end

  assign o_cs        = r_cs;
  assign o_sclk      = r_sclk;
  assign o_conv_done = r_done;
  assign o_data      = r_data;

endmodule

// File: rtl/stonyman_readout.sv
// Stonyman frame readout sequencer. On a start pulse it walks the sensor
// pointers in raster order (resv/resp reset, incp/incv advance), enables the
// amplifier (inphi), digitises each pixel through adc_spi_rx and emits one
// pix_valid strobe per pixel with its row/column. frame_done pulses after
// the last pixel. abort cancels from any state; no partial pixel is emitted.
// Ports:
//   FAB_CLK, MSS_RESET_N      clock, asynchronous active-low reset
//   start, abort              frame request / synchronous cancel
//   busy, startCaptureTP      frame in progress (test point mirrors busy)
//   frame_done                one-cycle end-of-frame pulse
//   resv, incv, resp, incp    sensor pointer pulses
//   inphi                     sensor amplifier enable
//   cs, SPI_CLK, miso         serial ADC interface
//   pix_data, pix_row, pix_col, pix_valid   pixel stream (no backpressure)
//   dbg_state                 current sequencer state
module stonyman_readout
  import stonyman_pkg::*;
#(
  parameter int ROWS       = 112,
  parameter int COLS       = 112,
  parameter int SCLK_DIV   = 2,
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 4
) (
  input  logic                FAB_CLK,
  input  logic                MSS_RESET_N,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                frame_done,
  output logic                startCaptureTP,
  output logic                resv,
  output logic                incv,
  output logic                resp,
  output logic                incp,
  output logic                inphi,
  output logic                cs,
  output logic                SPI_CLK,
  input  logic                miso,
  output logic [ADC_BITS-1:0] pix_data,
  output logic [COORD_W-1:0]  pix_row,
  output logic [COORD_W-1:0]  pix_col,
  output logic                pix_valid,
  output logic [3:0]          dbg_state
);

  localparam int TMR_MAX = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 2);
  // Pulse states last PULSE_CYC high cycles plus one low separation cycle.
  localparam logic [TMR_W-1:0]   PULSE_END  = TMR_W'(PULSE_CYC);
  localparam logic [TMR_W-1:0]   SETTLE_END = TMR_W'(SETTLE_CYC - 1);
  localparam logic [COORD_W-1:0] LAST_ROW   = COORD_W'(ROWS - 1);
  localparam logic [COORD_W-1:0] LAST_COL   = COORD_W'(COLS - 1);

  state_t               r_state;
  state_t               w_next;
  logic [TMR_W-1:0]     r_tmr;
  logic [COORD_W-1:0]   r_row;
  logic [COORD_W-1:0]   r_col;
  logic                 w_conv_start;
  logic                 w_conv_done;
  logic                 w_pulse;
  logic [ADC_BITS-1:0]  w_adc_data;

  always_comb begin
    w_next       = r_state;
    w_conv_start = 1'b0;
    case (r_state)
      S_IDLE:   if (start) w_next = S_RST_V;
      S_RST_V:  if (r_tmr == PULSE_END) w_next = S_RST_P;
      S_RST_P:  if (r_tmr == PULSE_END) w_next = S_SETTLE;
      S_INC_P:  if (r_tmr == PULSE_END) w_next = S_SETTLE;
      S_INC_V:  if (r_tmr == PULSE_END) w_next = S_RST_P;
      S_SETTLE: begin
        // launch on the last settle cycle so cs falls as CONV is entered
        if (r_tmr == SETTLE_END) begin
          w_next       = S_CONV;
          w_conv_start = 1'b1;
        end
      end
      S_CONV:   if (w_conv_done) w_next = S_EMIT;
      S_EMIT: begin
        if (r_col != LAST_COL)      w_next = S_INC_P;
        else if (r_row != LAST_ROW) w_next = S_INC_V;
        else                        w_next = S_DONE;
      end
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    // abort beats everything, including a start seen in IDLE
    if (abort) begin
      w_next       = S_IDLE;
      w_conv_start = 1'b0;
    end
  end

  always_ff @(posedge FAB_CLK or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) begin
      r_state <= S_IDLE;
      r_tmr   <= '0;
      r_row   <= '0;
      r_col   <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_tmr <= '0;
        case (w_next)
          S_IDLE:  begin r_row <= '0; r_col <= '0; end
          S_RST_V: r_row <= '0;
          S_RST_P: r_col <= '0;
          S_INC_P: r_col <= r_col + COORD_W'(1);
          S_INC_V: r_row <= r_row + COORD_W'(1);
          default: ;
        endcase
      end else if (r_tmr != {TMR_W{1'b1}}) begin
        r_tmr <= r_tmr + TMR_W'(1);
      end
    end
  end

  adc_spi_rx #(.SCLK_DIV(SCLK_DIV)) u_adc (
    .clk          (FAB_CLK),
    .rst_n        (MSS_RESET_N),
    .i_conv_start (w_conv_start),
    .i_abort      (abort),
    .i_miso       (miso),
    .o_cs         (cs),
    .o_sclk       (SPI_CLK),
    .o_conv_done  (w_conv_done),
    .o_data       (w_adc_data)
  );

  assign w_pulse        = (r_tmr < PULSE_END);
  assign resv           = (r_state == S_RST_V) && w_pulse;
  assign resp           = (r_state == S_RST_P) && w_pulse;
  assign incp           = (r_state == S_INC_P) && w_pulse;
  assign incv           = (r_state == S_INC_V) && w_pulse;
  assign inphi          = (r_state == S_SETTLE) || (r_state == S_CONV);
  assign pix_valid      = (r_state == S_EMIT);
  assign frame_done     = (r_state == S_DONE);
  assign busy           = (r_state != S_IDLE);
  assign startCaptureTP = busy;
  assign pix_data       = w_adc_data;
  assign pix_row        = r_row;
  assign pix_col        = r_col;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_stonyman_readout.sv
// Testbench for stonyman_readout on a 2x3 frame with SCLK_DIV=1.
// A behavioural ADC model serves per-pixel words; a scoreboard queue holds the
// raster-order pixels the frame must produce; a per-cycle monitor measures
// pulse widths/counts, inphi windows and SPI framing.
module tb_stonyman_readout;

  localparam int ROWS       = 2;
  localparam int COLS       = 3;
  localparam int SCLK_DIV   = 1;
  localparam int PULSE_CYC  = 2;
  localparam int SETTLE_CYC = 4;
  localparam int NPIX       = ROWS * COLS;
  localparam int CS_LOW     = 32 * SCLK_DIV;
  localparam int INPHI_W    = SETTLE_CYC + CS_LOW + 1;

  // ---------------- clock / reset ----------------
  logic        FAB_CLK = 1'b0;
  logic        MSS_RESET_N;
  logic        start, abort, miso;
  logic        busy, frame_done, startCaptureTP;
  logic        resv, incv, resp, incp, inphi, cs, SPI_CLK, pix_valid;
  logic [11:0] pix_data;
  logic [6:0]  pix_row, pix_col;
  logic [3:0]  dbg_state;

  always #5 FAB_CLK = ~FAB_CLK;

  stonyman_readout #(
    .ROWS(ROWS), .COLS(COLS), .SCLK_DIV(SCLK_DIV),
    .PULSE_CYC(PULSE_CYC), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .FAB_CLK(FAB_CLK), .MSS_RESET_N(MSS_RESET_N), .start(start), .abort(abort),
    .busy(busy), .frame_done(frame_done), .startCaptureTP(startCaptureTP),
    .resv(resv), .incv(incv), .resp(resp), .incp(incp), .inphi(inphi),
    .cs(cs), .SPI_CLK(SPI_CLK), .miso(miso),
    .pix_data(pix_data), .pix_row(pix_row), .pix_col(pix_col),
    .pix_valid(pix_valid), .dbg_state(dbg_state)
  );

  // ---------------- test vectors ----------------
  typedef struct {
    int lead_mode;   // 0: zeros, 1: ones, 2: random nibble in leading bits
    int rand_pix;    // 0: row*16+col+1, 1: random 12-bit pixels
    int restart_at;  // cycle of a second start pulse mid-frame (0 = none)
    int exp_strobes;
    int exp_done;
    int exp_resv, exp_resp, exp_incp, exp_incv;
  } vec_t;
  vec_t vecs[4];

  // ---------------- ADC behavioural model ----------------
  logic [11:0] pix_tab[NPIX];
  int          lead_mode = 0;
  int          conv_base = 0;
  int          conv_total = 0;
  int          fall_idx = 0;
  int          cur_idx;
  logic [3:0]  cur_lead;
  logic [15:0] cur_word;

  // The k-th conversion after a start digitises raster pixel k; a new bit is
  // presented on every falling SPI_CLK edge while cs is low.
  always @(negedge SPI_CLK or posedge cs) begin
    if (cs) begin
      if (fall_idx != 0) conv_total = conv_total + 1;
      fall_idx = 0;
    end else begin
      if (fall_idx == 0) begin
        cur_idx  = conv_total - conv_base;
        cur_lead = (lead_mode == 0) ? 4'h0 : (lead_mode == 1) ? 4'hF : 4'($urandom_range(0, 15));
        cur_word = {cur_lead, (cur_idx >= 0 && cur_idx < NPIX) ? pix_tab[cur_idx] : 12'h000};
      end
      if (fall_idx < 16) miso = cur_word[15 - fall_idx];
      fall_idx = fall_idx + 1;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [25:0] exp_q[$];   // {row[6:0], col[6:0], data[11:0]}
  int    n_checks = 0;
  int    n_fail = 0;
  string pname[4] = '{"resv", "resp", "incp", "incv"};
  int    p_run[4], p_cnt[4];
  logic  prev_p[4];
  int    inphi_run, cs_run, sclk_rises, strobes, dones;
  logic  prev_inphi, prev_cs, prev_sclk;
  bit    busy_low_due;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mon_resync();
    prev_p[0] = resv; prev_p[1] = resp; prev_p[2] = incp; prev_p[3] = incv;
    for (int i = 0; i < 4; i++) p_run[i] = 0;
    prev_inphi = inphi; prev_cs = cs; prev_sclk = SPI_CLK;
    inphi_run = 0; cs_run = 0; sclk_rises = 0; busy_low_due = 0;
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    logic p[4];
    logic [25:0] e;
    @(posedge FAB_CLK); #1;
    p[0] = resv; p[1] = resp; p[2] = incp; p[3] = incv;
    if (busy_low_due) begin
      chk("busy_after_done", busy, 0);
      chk("tp_after_done", startCaptureTP, 0);
      busy_low_due = 0;
    end
    if (cs) chk("sclk_idle_high", SPI_CLK, 1);
    for (int i = 0; i < 4; i++) begin
      if (p[i]) p_run[i]++;
      else if (prev_p[i]) begin
        p_cnt[i]++;
        chk({pname[i], "_width"}, p_run[i], PULSE_CYC);
        p_run[i] = 0;
      end
    end
    if (inphi) inphi_run++;
    else if (prev_inphi) begin
      chk("inphi_width", inphi_run, INPHI_W);
      inphi_run = 0;
    end
    if (!cs) begin
      cs_run++;
      if (SPI_CLK && !prev_sclk) sclk_rises++;
    end else if (!prev_cs) begin
      chk("cs_low_len", cs_run, CS_LOW);
      chk("sclk_rises", sclk_rises, 16);
      cs_run = 0; sclk_rises = 0;
    end
    if (pix_valid) begin
      strobes++;
      if (exp_q.size() == 0) chk("strobe_unexpected", pix_valid, 0);
      else begin
        e = exp_q.pop_front();
        chk("pix_row", pix_row, e[25:19]);
        chk("pix_col", pix_col, e[18:12]);
        chk("pix_data", pix_data, e[11:0]);
      end
    end
    if (frame_done) begin
      dones++;
      chk("busy_in_done", busy, 1);
      busy_low_due = 1;
    end
    for (int i = 0; i < 4; i++) prev_p[i] = p[i];
    prev_inphi = inphi; prev_cs = cs; prev_sclk = SPI_CLK;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_tp"}, startCaptureTP, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_pulses"}, {resv, incv, resp, incp}, 4'b0000);
    chk({tag, "_inphi"}, inphi, 0);
    chk({tag, "_cs"}, cs, 1);
    chk({tag, "_sclk"}, SPI_CLK, 1);
    chk({tag, "_pix_valid"}, pix_valid, 0);
    chk({tag, "_pix_data"}, pix_data, 0);
    chk({tag, "_pix_row"}, pix_row, 0);
    chk({tag, "_pix_col"}, pix_col, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic begin_frame(input int vi);
    exp_q.delete();
    lead_mode = vecs[vi].lead_mode;
    for (int i = 0; i < NPIX; i++) begin
      pix_tab[i] = (vecs[vi].rand_pix != 0) ? 12'($urandom_range(0, 4095))
                                            : 12'((i / COLS) * 16 + (i % COLS) + 1);
      exp_q.push_back({7'(i / COLS), 7'(i % COLS), pix_tab[i]});
    end
    strobes = 0; dones = 0;
    for (int i = 0; i < 4; i++) p_cnt[i] = 0;
    conv_base = conv_total;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("tp_after_start", startCaptureTP, 1);
  endtask

  task automatic run_frame(input int vi);
    begin_frame(vi);
    for (int cyc = 1; cyc <= 3000 && dones == 0; cyc++) begin
      start = (cyc == vecs[vi].restart_at);
      tick();
    end
    start = 1'b0;
    chk("frame_done_seen", dones, vecs[vi].exp_done);
    tick();
    repeat (10) tick();
    chk("strobe_count", strobes, vecs[vi].exp_strobes);
    chk("frame_done_count", dones, vecs[vi].exp_done);
    chk("exp_q_left", exp_q.size(), 0);
    chk("resv_count", p_cnt[0], vecs[vi].exp_resv);
    chk("resp_count", p_cnt[1], vecs[vi].exp_resp);
    chk("incp_count", p_cnt[2], vecs[vi].exp_incp);
    chk("incv_count", p_cnt[3], vecs[vi].exp_incv);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int e_cnt, s0, d0;
    logic last_sclk;
    vecs[0] = '{0, 0, 0,  NPIX, 1, 1, ROWS, ROWS * (COLS - 1), ROWS - 1};
    vecs[1] = '{1, 0, 0,  NPIX, 1, 1, ROWS, ROWS * (COLS - 1), ROWS - 1};
    vecs[2] = '{2, 1, 0,  NPIX, 1, 1, ROWS, ROWS * (COLS - 1), ROWS - 1};
    vecs[3] = '{2, 1, 60, NPIX, 1, 1, ROWS, ROWS * (COLS - 1), ROWS - 1};

    MSS_RESET_N = 1'b0; start = 1'b0; abort = 1'b0; miso = 1'b0;
    repeat (3) @(posedge FAB_CLK);
    #1 check_reset_values("reset");
    #2 MSS_RESET_N = 1'b1;
    mon_resync();
    tick();
    check_reset_values("idle");

    // abort and start together: abort wins
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_beats_start", busy, 0);
    tick();
    chk("abort_beats_start_2", busy, 0);

    // table-driven frames
    for (int vi = 0; vi < 4; vi++) begin
      repeat ($urandom_range(1, 5)) tick();
      run_frame(vi);
    end

    // abort at the 3rd SPI_CLK edge of pixel (0,1)
    begin_frame(0);
    for (int i = 0; i < 3000 && !(strobes == 1 && !cs); i++) tick();
    chk("abort_reach_pix01", {strobes[7:0], cs}, {8'd1, 1'b0});
    e_cnt = 1;  // cs falls together with the first (falling) SPI_CLK edge
    for (int i = 0; i < 100 && e_cnt < 3; i++) begin
      last_sclk = SPI_CLK;
      tick();
      if (SPI_CLK != last_sclk) e_cnt++;
    end
    abort = 1'b1;
    @(posedge FAB_CLK); #1;
    abort = 1'b0;
    chk("abort_cs", cs, 1);
    chk("abort_sclk", SPI_CLK, 1);
    chk("abort_busy", busy, 0);
    chk("abort_tp", startCaptureTP, 0);
    chk("abort_inphi", inphi, 0);
    chk("abort_pix_valid", pix_valid, 0);
    chk("abort_frame_done", frame_done, 0);
    mon_resync();
    exp_q.delete();
    s0 = strobes; d0 = dones;
    repeat (60) tick();
    chk("abort_no_strobe", strobes, s0);
    chk("abort_no_done", dones, d0);
    run_frame(0);

    // asynchronous reset mid-conversion of pixel (1,0)
    begin_frame(2);
    for (int i = 0; i < 3000 && !(strobes == 3 && !cs); i++) tick();
    chk("arst_reach_pix10", {strobes[7:0], cs}, {8'd3, 1'b0});
    repeat (5) tick();
    #3 MSS_RESET_N = 1'b0;
    #1 check_reset_values("arst");
    repeat (2) @(posedge FAB_CLK);
    #2 MSS_RESET_N = 1'b1;
    mon_resync();
    exp_q.delete();
    tick();
    check_reset_values("arst_idle");
    run_frame(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
